mem_arbiter: RTL and testbench

//   Shares the single main-memory bus between icache and dcache. Each cycle it grants at most
//   one requester's command, forwards the memory's acceptance tag to that requester only, and

---
 rtl/mem_arbiter_pkg.sv | 20 ++
 rtl/mem_tag_table.sv | 47 ++++
 rtl/mem_arbiter.sv | 150 +++++++++++++++
 tb/tb_mem_arbiter.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared types for the icache/dcache main-memory arbiter
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'h0,
    BUS_LOAD  = 2'h1,
    BUS_STORE = 2'h2
  } BUS_COMMAND;

  typedef enum logic {
    REQ_ICACHE = 1'b0,
    REQ_DCACHE = 1'b1
  } MEM_REQ_ID;

  typedef struct packed {
    logic      vld;
    MEM_REQ_ID owner;
  } TAG_OWNER_ENTRY;

endpackage

// File: rtl/mem_tag_table.sv
// rtl/mem_tag_table.sv - memory tag owner table, one set port, one clear port, one lookup
module mem_tag_table
  import mem_arbiter_pkg::*;
#(
  parameter int TAG_W = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             set_en,
  input  logic [TAG_W-1:0] set_tag,
  input  MEM_REQ_ID        set_owner,
  input  logic             clr_en,
  input  logic [TAG_W-1:0] clr_tag,
  input  logic [TAG_W-1:0] lookup_tag,
  output TAG_OWNER_ENTRY   lookup_entry
);

  localparam int N = 1 << TAG_W;

  TAG_OWNER_ENTRY tbl_q [N];
  TAG_OWNER_ENTRY tbl_d [N];

  // Clear before set, so a tag returned and reissued in one cycle ends valid with the new owner.
  always_comb begin
    tbl_d = tbl_q;
    if (clr_en) tbl_d[clr_tag] = '{vld: 1'b0, owner: REQ_ICACHE};
    if (set_en) tbl_d[set_tag] = '{vld: 1'b1, owner: set_owner};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < N; i++) tbl_q[i] <= '{vld: 1'b0, owner: REQ_ICACHE};
    end else begin
      tbl_q <= tbl_d;
    end
  end

  assign lookup_entry = tbl_q[lookup_tag];

  always_ff @(posedge clock) begin
    if (!reset) begin
      assert (!(set_en && tbl_q[set_tag].vld && !(clr_en && clr_tag == set_tag)))
        else $warning("memory reissued tag %0d while still outstanding", set_tag);
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - icache/dcache arbiter for the main-memory bus with tag return steering
// MEM_ARB_STATS_EN adds saturating icache_grants, dcache_grants and conflicts counters.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int TAG_W      = 4,
  parameter int STARVE_MAX = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [1:0]       icache2ctlr_command,
  input  logic [XLEN-1:0]  icache2ctlr_addr,
  input  logic [1:0]       dcache2ctlr_command,
  input  logic [XLEN-1:0]  dcache2ctlr_addr,
  input  logic [63:0]      dcache2ctlr_data,
  input  logic [TAG_W-1:0] mem2ctlr_response,
  input  logic [63:0]      mem2ctlr_data,
  input  logic [TAG_W-1:0] mem2ctlr_tag,
  output logic [1:0]       ctlr2mem_command,
  output logic [XLEN-1:0]  ctlr2mem_addr,
  output logic [63:0]      ctlr2mem_data,
  output logic [TAG_W-1:0] Ctlr2icache_response,
  output logic [TAG_W-1:0] Ctlr2proc_response,
  output logic [TAG_W-1:0] Ctlr2icache_tag,
  output logic [TAG_W-1:0] Ctlr2proc_tag,
  output logic [63:0]      Ctlr2icache_data,
  output logic [63:0]      Ctlr2proc_data
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [31:0]      icache_grants,
  output logic [31:0]      dcache_grants,
  output logic [31:0]      conflicts
`endif
);

  localparam int SW = $clog2(STARVE_MAX + 1);

  logic [SW-1:0]  starve_q, starve_d;
  logic           i_act, d_act, grant_i, grant_d, accepted, ret_hit;
  TAG_OWNER_ENTRY lookup_entry;

  always_comb begin
    i_act    = icache2ctlr_command != BUS_NONE;
    d_act    = dcache2ctlr_command != BUS_NONE;
    grant_i  = i_act && (!d_act || starve_q == SW'(STARVE_MAX));
    grant_d  = d_act && !grant_i;
    accepted = (grant_i || grant_d) && (mem2ctlr_response != '0);
    ret_hit  = (mem2ctlr_tag != '0) && lookup_entry.vld;
  end

  // A granted-but-rejected icache keeps its count so it stays ahead on the retry.
  always_comb begin
    starve_d = starve_q;
    if (!i_act)
      starve_d = '0;
    else if (grant_i)
      starve_d = accepted ? '0 : starve_q;
    else if (starve_q != SW'(STARVE_MAX))
      starve_d = starve_q + SW'(1);
  end

  always_ff @(posedge clock) begin
    if (reset) starve_q <= '0;
    else       starve_q <= starve_d;
  end

  mem_tag_table #(.TAG_W(TAG_W)) u_tag_table (
    .clock        (clock),
    .reset        (reset),
    .set_en       (accepted),
    .set_tag      (mem2ctlr_response),
    .set_owner    (grant_i ? REQ_ICACHE : REQ_DCACHE),
    .clr_en       (ret_hit),
    .clr_tag      (mem2ctlr_tag),
    .lookup_tag   (mem2ctlr_tag),
    .lookup_entry (lookup_entry)
  );

  always_comb begin
    ctlr2mem_command     = BUS_NONE;
    ctlr2mem_addr        = '0;
    ctlr2mem_data        = '0;
    Ctlr2icache_response = '0;
    Ctlr2proc_response   = '0;
    Ctlr2icache_tag      = '0;
    Ctlr2proc_tag        = '0;
    Ctlr2icache_data     = '0;
    Ctlr2proc_data       = '0;
    if (!reset) begin
      if (grant_i) begin
        ctlr2mem_command = icache2ctlr_command;
        ctlr2mem_addr    = icache2ctlr_addr;
      end else if (grant_d) begin
        ctlr2mem_command = dcache2ctlr_command;
        ctlr2mem_addr    = dcache2ctlr_addr;
        ctlr2mem_data    = dcache2ctlr_data;
      end
      if (accepted) begin
        if (grant_i) Ctlr2icache_response = mem2ctlr_response;
        else         Ctlr2proc_response   = mem2ctlr_response;
      end
      if (ret_hit) begin
        if (lookup_entry.owner == REQ_ICACHE) Ctlr2icache_tag = mem2ctlr_tag;
        else                                  Ctlr2proc_tag   = mem2ctlr_tag;
      end
      Ctlr2icache_data = mem2ctlr_data;
      Ctlr2proc_data   = mem2ctlr_data;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      assert (!(mem2ctlr_tag != '0 && !lookup_entry.vld))
        else $warning("return tag %0d has no owner, dropped", mem2ctlr_tag);
    end
  end

`ifdef MEM_ARB_STATS_EN
  logic [31:0] icache_grants_q, icache_grants_d;
  logic [31:0] dcache_grants_q, dcache_grants_d;
  logic [31:0] conflicts_q, conflicts_d;

  always_comb begin
    icache_grants_d = icache_grants_q;
    dcache_grants_d = dcache_grants_q;
    conflicts_d     = conflicts_q;
    if (accepted && grant_i && icache_grants_q != '1) icache_grants_d = icache_grants_q + 32'd1;
    if (accepted && grant_d && dcache_grants_q != '1) dcache_grants_d = dcache_grants_q + 32'd1;
    if (i_act && d_act && conflicts_q != '1)          conflicts_d     = conflicts_q + 32'd1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      icache_grants_q <= '0;
      dcache_grants_q <= '0;
      conflicts_q     <= '0;
    end else begin
      icache_grants_q <= icache_grants_d;
      dcache_grants_q <= dcache_grants_d;
      conflicts_q     <= conflicts_d;
    end
  end

  assign icache_grants = reset ? '0 : icache_grants_q;
  assign dcache_grants = reset ? '0 : dcache_grants_q;
  assign conflicts     = reset ? '0 : conflicts_q;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed and randomized checks of mem_arbiter against a reference model
module tb_mem_arbiter;

  localparam int XLEN = 32;

  logic              clock = 1'b0;
  logic              reset;
  logic [1:0]        icmd, dcmd;
  logic [XLEN-1:0]   iaddr, daddr;
  logic [63:0]       ddata, rdata;
  logic [3:0]        resp, rtag;
  logic [1:0]        m_cmd;
  logic [XLEN-1:0]   m_addr;
  logic [63:0]       m_data, i_data, p_data;
  logic [3:0]        i_resp, p_resp, i_tag, p_tag;
`ifdef MEM_ARB_STATS_EN
  logic [31:0]       st_ig, st_dg, st_cf;
`endif

  mem_arbiter #(.XLEN(XLEN), .TAG_W(4), .STARVE_MAX(4)) dut (
    .clock                (clock),
    .reset                (reset),
    .icache2ctlr_command  (icmd),
    .icache2ctlr_addr     (iaddr),
    .dcache2ctlr_command  (dcmd),
    .dcache2ctlr_addr     (daddr),
    .dcache2ctlr_data     (ddata),
    .mem2ctlr_response    (resp),
    .mem2ctlr_data        (rdata),
    .mem2ctlr_tag         (rtag),
    .ctlr2mem_command     (m_cmd),
    .ctlr2mem_addr        (m_addr),
    .ctlr2mem_data        (m_data),
    .Ctlr2icache_response (i_resp),
    .Ctlr2proc_response   (p_resp),
    .Ctlr2icache_tag      (i_tag),
    .Ctlr2proc_tag        (p_tag),
    .Ctlr2icache_data     (i_data),
    .Ctlr2proc_data       (p_data)
`ifdef MEM_ARB_STATS_EN
    ,
    .icache_grants        (st_ig),
    .dcache_grants        (st_dg),
    .conflicts            (st_cf)
`endif
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;

  // Reference model state: owner map (1 = dcache), icache denial streak, statistics.
  bit          mvld [16];
  bit          mown [16];
  int          starve;
  int unsigned m_ig, m_dg, m_cf;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
      else begin
        fails++;
        $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [1:0] ic, input logic [XLEN-1:0] ia, input logic [1:0] dc,
                       input logic [XLEN-1:0] da, input logic [63:0] dd, input logic [3:0] rs,
                       input logic [3:0] rt, input logic [63:0] rd);
    icmd = ic; iaddr = ia; dcmd = dc; daddr = da; ddata = dd;
    resp = rs; rtag = rt; rdata = rd;
  endtask

  task automatic model_reset();
    for (int t = 0; t < 16; t++) begin mvld[t] = 0; mown[t] = 0; end
    starve = 0; m_ig = 0; m_dg = 0; m_cf = 0;
  endtask

  // Expected outputs from the arbitration rules, checked mid-cycle, then state advanced across the edge.
  task automatic model_cycle();
    bit ia, da, gi, gd, acc, hit;
    ia  = icmd != 2'd0;
    da  = dcmd != 2'd0;
    gi  = ia && (!da || starve >= 4);
    gd  = da && !gi;
    acc = (gi || gd) && resp != 4'd0;
    hit = rtag != 4'd0 && mvld[rtag];
    check("rnd_cmd",    m_cmd,  gi ? icmd : gd ? dcmd : 2'd0);
    check("rnd_addr",   m_addr, gi ? iaddr : gd ? daddr : '0);
    check("rnd_mdata",  m_data, gd ? ddata : 64'd0);
    check("rnd_iresp",  i_resp, (acc && gi) ? resp : 4'd0);
    check("rnd_presp",  p_resp, (acc && gd) ? resp : 4'd0);
    check("rnd_itag",   i_tag,  (hit && !mown[rtag]) ? rtag : 4'd0);
    check("rnd_ptag",   p_tag,  (hit && mown[rtag]) ? rtag : 4'd0);
    check("rnd_idata",  i_data, rdata);
    tick();
    if (hit) mvld[rtag] = 0;
    if (acc) begin mvld[resp] = 1; mown[resp] = gd; end
    if (!ia)             starve = 0;
    else if (gi && acc)  starve = 0;
    else if (!gi)        starve = (starve < 4) ? starve + 1 : 4;
    if (acc && gi) m_ig++;
    if (acc && gd) m_dg++;
    if (ia && da)  m_cf++;
  endtask

  initial begin
    int vq[$];
    int fq[$];

    // Reset: outputs forced quiet even with requests present.
    reset = 1'b1;
    drive(2'd1, 32'h40, 2'd1, 32'h100, 64'h77, 4'd3, 4'd3, 64'h1234);
    #4;
    check("rst_cmd",   m_cmd,  2'd0);
    check("rst_presp", p_resp, 4'd0);
    check("rst_ptag",  p_tag,  4'd0);
    check("rst_pdata", p_data, 64'd0);
    tick();
    tick();
    reset = 1'b0;
    drive(2'd0, '0, 2'd0, '0, 64'd0, 4'd0, 4'd0, 64'd0);
    tick();

    // 1: lone dcache load accepted with tag 3.
    drive(2'd0, '0, 2'd1, 32'h100, 64'h0, 4'd3, 4'd0, 64'd0);
    #4;
    check("t1_cmd",   m_cmd,  2'd1);
    check("t1_addr",  m_addr, 32'h100);
    check("t1_presp", p_resp, 4'd3);
    check("t1_iresp", i_resp, 4'd0);
    tick();

    // 2: four rejected conflict cycles, then icache is forced ahead and accepted with tag 5.
    for (int c = 0; c < 4; c++) begin
      drive(2'd1, 32'h200, 2'd2, 32'h300, 64'h55, 4'd0, 4'd0, 64'd0);
      #4;
      check("t2_dwins_addr", m_addr, 32'h300);
      check("t2_rej_resp",   {i_resp, p_resp}, 8'h00);
      tick();
    end
    drive(2'd1, 32'h200, 2'd2, 32'h300, 64'h55, 4'd5, 4'd0, 64'd0);
    #4;
    check("t2_iwins_addr", m_addr, 32'h200);
    check("t2_iwins_data", m_data, 64'd0);
    check("t2_iresp",      i_resp, 4'd5);
    check("t2_presp",      p_resp, 4'd0);
    tick();
    drive(2'd1, 32'h200, 2'd2, 32'h300, 64'h55, 4'd0, 4'd0, 64'd0);
    #4;
    check("t2_starve_clr", m_addr, 32'h300);
    tick();

    // 3: tag 5 returns to icache, then is gone.
    drive(2'd0, '0, 2'd0, '0, 64'd0, 4'd0, 4'd5, 64'hDEAD);
    #4;
    check("t3_itag",  i_tag,  4'd5);
    check("t3_ptag",  p_tag,  4'd0);
    check("t3_idata", i_data, 64'hDEAD);
    check("t3_pdata", p_data, 64'hDEAD);
    tick();
    #4;
    check("t3_cleared", {i_tag, p_tag}, 8'h00);
    tick();

    // 4: tag 7 returns to dcache while being reissued to icache in the same cycle.
    drive(2'd0, '0, 2'd1, 32'h700, 64'd0, 4'd7, 4'd0, 64'd0);
    tick();
    drive(2'd1, 32'h800, 2'd0, '0, 64'd0, 4'd7, 4'd7, 64'hBEEF);
    #4;
    check("t4_ptag",  p_tag,  4'd7);
    check("t4_itag",  i_tag,  4'd0);
    check("t4_iresp", i_resp, 4'd7);
    tick();
    drive(2'd0, '0, 2'd0, '0, 64'd0, 4'd0, 4'd7, 64'hF00D);
    #4;
    check("t4_newowner_itag", i_tag, 4'd7);
    check("t4_newowner_ptag", p_tag, 4'd0);
    tick();

    // 5: tags 1, 2, 3 outstanding across a reset are dropped afterwards.
    drive(2'd0, '0, 2'd1, 32'h10, 64'd0, 4'd1, 4'd0, 64'd0);
    tick();
    drive(2'd0, '0, 2'd1, 32'h18, 64'd0, 4'd2, 4'd0, 64'd0);
    tick();
    reset = 1'b1;
    drive(2'd0, '0, 2'd0, '0, 64'd0, 4'd0, 4'd3, 64'h99);
    #4;
    check("t5_rst_ptag", p_tag, 4'd0);
    tick();
    tick();
    reset = 1'b0;
    #4;
    check("t5_tag3", {i_tag, p_tag}, 8'h00);
    tick();
    rtag = 4'd1;
    #4;
    check("t5_tag1", {i_tag, p_tag}, 8'h00);
    tick();

    // Randomized traffic against the model, starting from a clean reset.
    reset = 1'b1;
    drive(2'd0, '0, 2'd0, '0, 64'd0, 4'd0, 4'd0, 64'd0);
    tick();
    reset = 1'b0;
    model_reset();
    for (int n = 0; n < 400; n++) begin
      vq.delete();
      fq.delete();
      for (int t = 1; t < 16; t++) if (mvld[t]) vq.push_back(t);
      icmd  = 2'($urandom_range(0, 2));
      dcmd  = 2'($urandom_range(0, 2));
      iaddr = {$urandom} & ~32'h7;
      daddr = {$urandom} & ~32'h7;
      ddata = {$urandom, $urandom};
      rdata = {$urandom, $urandom};
      rtag  = (vq.size() > 0 && $urandom_range(0, 1) == 1) ? 4'(vq[$urandom_range(0, vq.size() - 1)]) : 4'd0;
      for (int t = 1; t < 16; t++) if (!mvld[t] || t == int'(rtag)) fq.push_back(t);
      resp  = (fq.size() > 0 && $urandom_range(0, 1) == 1) ? 4'(fq[$urandom_range(0, fq.size() - 1)]) : 4'd0;
      #4;
      model_cycle();
    end

`ifdef MEM_ARB_STATS_EN
    check("rnd_icache_grants", st_ig, 64'(m_ig));
    check("rnd_dcache_grants", st_dg, 64'(m_dg));
    check("rnd_conflicts",     st_cf, 64'(m_cf));

    // 6: ten accepted dcache grants and two conflict cycles.
    reset = 1'b1;
    drive(2'd0, '0, 2'd0, '0, 64'd0, 4'd0, 4'd0, 64'd0);
    tick();
    reset = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      drive(2'd0, '0, 2'd1, 32'h1000 + 32'(k * 8), 64'd0, 4'(k), 4'd0, 64'd0);
      tick();
    end
    for (int k = 0; k < 2; k++) begin
      drive(2'd1, 32'h2000, 2'd1, 32'h3000, 64'd0, 4'd0, 4'd0, 64'd0);
      tick();
    end
    drive(2'd0, '0, 2'd0, '0, 64'd0, 4'd0, 4'd0, 64'd0);
    #4;
    check("t6_dcache_grants", st_dg, 64'd10);
    check("t6_conflicts",     st_cf, 64'd2);
    check("t6_icache_grants", st_ig, 64'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
